// File: rtl/gyro_tilt_integrator.sv
`default_nettype none
// ============================================================================
// Module   : gyro_tilt_integrator
// Brief    : Per-channel gyro rate integrator with bias calibration,
//            saturating accumulators and clamped tilt outputs.
//            Optional macro GYRO_DEADBAND_EN zeroes small corrected rates.
// Revision : 1.0 - initial release
// ============================================================================
module gyro_tilt_integrator #(
  parameter int NCH      = 3,
  parameter int DW       = 16,
  parameter int AW       = 24,
  parameter int SHIFT    = 4,
  parameter int CAL_LOG2 = 3,
  parameter int DEADBAND = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NCH*DW-1:0] din,
  input  logic              din_valid,
  input  logic              zero,
  input  logic              cal_start,
  output logic [NCH*DW-1:0] tilt,
  output logic              out_valid,
  output logic [NCH-1:0]    sat,
  output logic              busy,
  output logic              cal_done
);

  typedef enum logic [0:0] {
    RUN = 1'b0,
    CAL = 1'b1
  } state_t;

  localparam logic signed [AW-1:0] c_ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] c_ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [DW-1:0] c_OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] c_OUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam int                   c_SW      = DW + CAL_LOG2;

  state_t                     r_state;
  logic signed [AW-1:0]       r_acc  [NCH];
  logic signed [DW-1:0]       r_bias [NCH];
  logic signed [c_SW-1:0]     r_sum  [NCH];
  logic [CAL_LOG2-1:0]        r_cnt;

  logic signed [DW-1:0]       w_din      [NCH];
  logic signed [DW:0]         w_corr_raw [NCH];
  logic signed [DW:0]         w_corr     [NCH];
  logic signed [AW:0]         w_wide     [NCH];
  logic signed [AW-1:0]       w_acc_add  [NCH];
  logic signed [AW-1:0]       w_shr      [NCH];
  logic signed [DW-1:0]       w_tilt_new [NCH];
  logic signed [c_SW-1:0]     w_sum_new  [NCH];
  logic signed [DW-1:0]       w_bias_new [NCH];
  logic [NCH-1:0]             w_clip;
  logic [NCH-1:0]             w_fits;

  // Per-channel datapath: bias correction, saturating add, tilt scaling and calibration sum
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_din[gi]      = $signed(din[gi*DW +: DW]);
    assign w_corr_raw[gi] = {w_din[gi][DW-1], w_din[gi]} - {r_bias[gi][DW-1], r_bias[gi]};

`ifdef GYRO_DEADBAND_EN
    localparam logic signed [DW:0] c_DB = (DW+1)'(DEADBAND);
    assign w_corr[gi] = ((w_corr_raw[gi] <= c_DB) && (w_corr_raw[gi] >= -c_DB))
                        ? '0 : w_corr_raw[gi];
`else
    assign w_corr[gi] = w_corr_raw[gi];
`endif

    // One guard bit exposes overflow: the top two bits disagree when the AW range is exceeded
    assign w_wide[gi]    = {r_acc[gi][AW-1], r_acc[gi]}
                         + {{(AW-DW){w_corr[gi][DW]}}, w_corr[gi]};
    assign w_clip[gi]    = w_wide[gi][AW] ^ w_wide[gi][AW-1];
    assign w_acc_add[gi] = w_clip[gi] ? (w_wide[gi][AW] ? c_ACC_MIN : c_ACC_MAX)
                                      : w_wide[gi][AW-1:0];

    // Scaled accumulator fits in DW bits only when all bits above the DW sign bit agree
    assign w_shr[gi]      = w_acc_add[gi] >>> SHIFT;
    assign w_fits[gi]     = (&w_shr[gi][AW-1:DW-1]) | ~(|w_shr[gi][AW-1:DW-1]);
    assign w_tilt_new[gi] = w_fits[gi] ? w_shr[gi][DW-1:0]
                                       : (w_shr[gi][AW-1] ? c_OUT_MIN : c_OUT_MAX);

    // Raw-sample sum; keeping the upper DW bits is the arithmetic divide by 2^CAL_LOG2
    assign w_sum_new[gi]  = r_sum[gi] + {{CAL_LOG2{w_din[gi][DW-1]}}, w_din[gi]};
    assign w_bias_new[gi] = w_sum_new[gi][c_SW-1:CAL_LOG2];
  end

  // Control FSM with accumulators, bias, calibration sum and all registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      tilt      <= '0;
      out_valid <= 1'b0;
      sat       <= '0;
      busy      <= 1'b0;
      cal_done  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_acc[i]  <= '0;
        r_bias[i] <= '0;
        r_sum[i]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      cal_done  <= 1'b0;
      case (r_state)
        RUN: begin
          if (din_valid && !zero) begin
            out_valid <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
              r_acc[i]           <= w_acc_add[i];
              tilt[i*DW +: DW]   <= w_tilt_new[i];
              if (w_clip[i]) sat[i] <= 1'b1;
            end
          end
          if (cal_start) begin
            r_state <= CAL;
            busy    <= 1'b1;
            r_cnt   <= '0;
            for (int i = 0; i < NCH; i++) r_sum[i] <= '0;
          end
        end
        CAL: begin
          // A sample coinciding with zero is discarded here as well
          if (din_valid && !zero) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
              r_state  <= RUN;
              busy     <= 1'b0;
              cal_done <= 1'b1;
              tilt     <= '0;
              for (int i = 0; i < NCH; i++) begin
                r_bias[i] <= w_bias_new[i];
                r_acc[i]  <= '0;
                r_sum[i]  <= '0;
              end
            end else begin
              for (int i = 0; i < NCH; i++) r_sum[i] <= w_sum_new[i];
            end
          end
        end
        default: r_state <= RUN;
      endcase
      // Re-zero wins over any accumulation on the same edge; tilt follows the cleared accumulators
      if (zero) begin
        sat  <= '0;
        tilt <= '0;
        for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gyro_tilt_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_gyro_tilt_integrator
// Brief    : Scoreboard bench for gyro_tilt_integrator (NCH=3, DW=16, AW=24,
//            SHIFT=4, CAL_LOG2=3, DEADBAND=2). Honors GYRO_DEADBAND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gyro_tilt_integrator;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [47:0] din = '0;
  logic        din_valid = 1'b0;
  logic        zero = 1'b0;
  logic        cal_start = 1'b0;
  logic [47:0] tilt;
  logic        out_valid;
  logic [2:0]  sat;
  logic        busy;
  logic        cal_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  int       m_acc  [3];
  int       m_bias [3];
  int       m_sum  [3];
  int       m_cnt;
  bit       m_cal;
  logic [2:0] m_sat;

  // Expected {sat, tilt} per accepted RUN sample
  logic [50:0] sb[$];
  logic [50:0] exp_v;

  gyro_tilt_integrator #(
    .NCH(3), .DW(16), .AW(24), .SHIFT(4), .CAL_LOG2(3), .DEADBAND(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .din_valid(din_valid), .zero(zero),
    .cal_start(cal_start), .tilt(tilt), .out_valid(out_valid), .sat(sat),
    .busy(busy), .cal_done(cal_done)
  );

  always #5 CLK = ~CLK;

  function automatic int clampi(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [47:0] m_tilt_vec();
    logic [47:0] v;
    for (int i = 0; i < 3; i++) v[i*16 +: 16] = 16'(clampi(m_acc[i] >>> 4, -32768, 32767));
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_bias[i] = 0; m_sum[i] = 0;
    end
    m_cnt = 0; m_cal = 0; m_sat = '0;
    sb.delete();
  endtask

  // Drives one valid sample for one cycle and advances the model
  task automatic send(input int d0, input int d1, input int d2);
    int d[3];
    int corr, s;
    d[0] = d0; d[1] = d1; d[2] = d2;
    din = {16'(d2), 16'(d1), 16'(d0)};
    din_valid = 1'b1;
    if (!m_cal) begin
      for (int i = 0; i < 3; i++) begin
        corr = d[i] - m_bias[i];
`ifdef GYRO_DEADBAND_EN
        if (corr >= -2 && corr <= 2) corr = 0;
`endif
        s = m_acc[i] + corr;
        if (s > 8388607) begin s = 8388607; m_sat[i] = 1'b1; end
        else if (s < -8388608) begin s = -8388608; m_sat[i] = 1'b1; end
        m_acc[i] = s;
      end
      sb.push_back({m_sat, m_tilt_vec()});
    end else begin
      for (int i = 0; i < 3; i++) m_sum[i] += d[i];
      m_cnt++;
      if (m_cnt == 8) begin
        for (int i = 0; i < 3; i++) begin
          m_bias[i] = m_sum[i] >>> 3; m_acc[i] = 0; m_sum[i] = 0;
        end
        m_cnt = 0; m_cal = 0;
      end
    end
    @(posedge CLK); #1;
    din_valid = 1'b0;
  endtask

  task automatic do_zero();
    zero = 1'b1;
    @(posedge CLK); #1;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) m_acc[i] = 0;
    m_sat = '0;
  endtask

  task automatic pulse_cal();
    cal_start = 1'b1;
    @(posedge CLK); #1;
    cal_start = 1'b0;
    m_cal = 1; m_cnt = 0;
    for (int i = 0; i < 3; i++) m_sum[i] = 0;
  endtask

  task automatic test_reset();
    m_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total_cnt++;
    if (tilt !== 48'd0) $display("FAIL reset_tilt: got %h want 0", tilt); else pass_cnt++;
    total_cnt++;
    if (sat !== 3'b000) $display("FAIL reset_sat: got %b want 000", sat); else pass_cnt++;
    total_cnt++;
    if ({out_valid, busy, cal_done} !== 3'b000)
      $display("FAIL reset_flags: got ov/busy/done=%b want 000", {out_valid, busy, cal_done});
    else pass_cnt++;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_integrate();
    for (int k = 0; k < 4; k++) begin
      send(16, 0, 0);
      exp_v = sb.pop_front();
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL integ_valid[%0d]: got %b want 1", k, out_valid); else pass_cnt++;
      total_cnt++;
      if ({sat, tilt} !== exp_v) $display("FAIL integ_tilt[%0d]: got %h want %h", k, {sat, tilt}, exp_v); else pass_cnt++;
    end
    total_cnt++;
    if (tilt !== {16'd0, 16'd0, 16'd4}) $display("FAIL integ_final: got %h want 000000000004", tilt); else pass_cnt++;
  endtask

  task automatic test_calibration();
    pulse_cal();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL cal_busy_start: got %b want 1", busy); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      send(100, 0, 0);
      total_cnt++;
      if (k < 7) begin
        if ({busy, cal_done, out_valid} !== 3'b100)
          $display("FAIL cal_step[%0d]: got busy/done/ov=%b want 100", k, {busy, cal_done, out_valid});
        else pass_cnt++;
      end else begin
        if ({busy, cal_done, out_valid} !== 3'b010)
          $display("FAIL cal_exit: got busy/done/ov=%b want 010", {busy, cal_done, out_valid});
        else pass_cnt++;
      end
    end
    @(posedge CLK); #1;
    total_cnt++;
    if (cal_done !== 1'b0) $display("FAIL cal_done_pulse: got %b want 0", cal_done); else pass_cnt++;
    send(100, 0, 0);
    exp_v = sb.pop_front();
    total_cnt++;
    if ({sat, tilt} !== exp_v || out_valid !== 1'b1 || tilt[15:0] !== 16'd0)
      $display("FAIL cal_bias_zero: got ov=%b %h want ov=1 %h", out_valid, {sat, tilt}, exp_v);
    else pass_cnt++;
    send(116, 0, 0);
    exp_v = sb.pop_front();
    total_cnt++;
    if ({sat, tilt} !== exp_v || tilt[15:0] !== 16'd1)
      $display("FAIL cal_bias_plus16: got %h want %h", {sat, tilt}, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_zero();
    for (int k = 1; k <= 257; k++) begin
      send(100, 32767, 0);
      exp_v = sb.pop_front();
      total_cnt++;
      if ({sat, tilt} !== exp_v || out_valid !== 1'b1)
        $display("FAIL sat_stream[%0d]: got ov=%b %h want ov=1 %h", k, out_valid, {sat, tilt}, exp_v);
      else pass_cnt++;
      if (k == 256) begin
        total_cnt++;
        if (sat[1] !== 1'b0) $display("FAIL sat_not_yet: got %b want 0", sat[1]); else pass_cnt++;
      end
    end
    total_cnt++;
    if (sat[1] !== 1'b1 || tilt[31:16] !== 16'h7fff)
      $display("FAIL sat_limit: got sat1=%b tilt1=%h want 1 7fff", sat[1], tilt[31:16]);
    else pass_cnt++;
    do_zero();
    total_cnt++;
    if (sat !== 3'b000 || tilt[31:16] !== 16'd0)
      $display("FAIL sat_zero: got sat=%b tilt1=%h want 000 0000", sat, tilt[31:16]);
    else pass_cnt++;
  endtask

  task automatic test_deadband();
    do_zero();
    for (int k = 0; k < 10; k++) begin
      send(100, 0, 2);
      exp_v = sb.pop_front();
      total_cnt++;
      if ({sat, tilt} !== exp_v) $display("FAIL db_stream[%0d]: got %h want %h", k, {sat, tilt}, exp_v); else pass_cnt++;
    end
    total_cnt++;
`ifdef GYRO_DEADBAND_EN
    if (tilt[47:32] !== 16'd0) $display("FAIL db_final: got %h want 0000", tilt[47:32]); else pass_cnt++;
`else
    if (tilt[47:32] !== 16'd1) $display("FAIL db_final: got %h want 0001", tilt[47:32]); else pass_cnt++;
`endif
  endtask

  task automatic test_zero_precedence();
    din = {16'd0, 16'd0, 16'd150};
    din_valid = 1'b1;
    zero = 1'b1;
    @(posedge CLK); #1;
    din_valid = 1'b0;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) m_acc[i] = 0;
    m_sat = '0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL zp_valid: got %b want 0", out_valid); else pass_cnt++;
    send(116, 0, 0);
    exp_v = sb.pop_front();
    total_cnt++;
    if ({sat, tilt} !== exp_v || tilt[15:0] !== 16'd1)
      $display("FAIL zp_acc_clear: got %h want %h", {sat, tilt}, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_zero();
    for (int k = 0; k < 20; k++) begin
      send(int'($urandom_range(600)) - 300, int'($urandom_range(600)) - 300,
           int'($urandom_range(600)) - 300);
      exp_v = sb.pop_front();
      total_cnt++;
      if ({sat, tilt} !== exp_v || out_valid !== 1'b1)
        $display("FAIL b2b[%0d]: got ov=%b %h want ov=1 %h", k, out_valid, {sat, tilt}, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_cal();
    bit seen_done;
    pulse_cal();
    for (int k = 0; k < 4; k++) send(40, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    m_reset();
    total_cnt++;
    if (busy !== 1'b0 || tilt !== 48'd0 || sat !== 3'b000)
      $display("FAIL rmc_async: got busy=%b tilt=%h sat=%b want 0 0 000", busy, tilt, sat);
    else pass_cnt++;
    @(negedge CLK);
    RST_N = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      if (cal_done === 1'b1) seen_done = 1;
    end
    total_cnt++;
    if (seen_done) $display("FAIL rmc_no_done: got pulse 1 want 0"); else pass_cnt++;
    send(16, 0, 0);
    exp_v = sb.pop_front();
    total_cnt++;
    if ({sat, tilt} !== exp_v || tilt[15:0] !== 16'd1)
      $display("FAIL rmc_bias_cleared: got %h want %h", {sat, tilt}, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_calibration();
    test_saturation();
    test_deadband();
    test_zero_precedence();
    test_back_to_back();
    test_reset_mid_cal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
